// File: rtl/irq_vector_ctrl_if.sv
// irq_vector_ctrl_if: CPU-side handshake of the interrupt controller.
// The controller presents a vector; the CPU acknowledges and returns.
interface irq_vector_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int IDX_W  = 2
);
   logic              o_int_req;
   logic [ADDR_W-1:0] o_interrupt_address;
   logic [IDX_W-1:0]  o_int_id;
   logic              o_int_soft;
   logic              o_pc_set_enable;
   logic              o_recovery_enable;
   logic              i_ack;
   logic              i_iret;

   modport master (
      output o_int_req,
      output o_interrupt_address,
      output o_int_id,
      output o_int_soft,
      output o_pc_set_enable,
      output o_recovery_enable,
      input  i_ack,
      input  i_iret
   );

   modport slave (
      input  o_int_req,
      input  o_interrupt_address,
      input  o_int_id,
      input  o_int_soft,
      input  o_pc_set_enable,
      input  o_recovery_enable,
      output i_ack,
      output i_iret
   );
endinterface

// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl: vectored interrupt controller, edge-detected channels,
// fixed or round-robin priority, one soft slot, no nesting.
module irq_vector_ctrl #(
   parameter int NUM_IRQ = 4,
   parameter int ADDR_W  = 16,
   parameter logic [ADDR_W-1:0] DEF_BASE  = 16'hFDA9,
   parameter logic [ADDR_W-1:0] DEF_STEP  = 16'h0256,
   parameter logic [ADDR_W-1:0] SOFT_BASE = 16'd29,
   localparam int IDX_W = (NUM_IRQ > 2) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic               i_cfg_we,
   input  logic [1:0]         i_cfg_op,
   input  logic [IDX_W-1:0]   i_cfg_idx,
   input  logic [ADDR_W-1:0]  i_data_bus,
   input  logic               i_soft_req,
   input  logic [4:0]         i_soft_num,
   irq_vector_ctrl_if.master  cpu,
   output logic [NUM_IRQ-1:0] o_pending,
   output logic               o_busy
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_IRQ - 1);

   state_t              state_q;
   logic [NUM_IRQ-1:0]  irq_q;
   logic [NUM_IRQ-1:0]  pend_q;
   logic [NUM_IRQ-1:0]  mask_q;
   logic [NUM_IRQ-1:0]  edge_w;
   logic [NUM_IRQ-1:0]  elig_w;
   logic [NUM_IRQ-1:0]  hw_clr;
   logic                soft_pend_q;
   logic [4:0]          soft_num_q;
   logic                mode_q;
   logic [IDX_W-1:0]    rr_q;
   logic [ADDR_W-1:0]   vec_q [NUM_IRQ];
   logic [ADDR_W-1:0]   lat_vec_q;
   logic [IDX_W-1:0]    lat_id_q;
   logic                lat_soft_q;
   logic                req_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                pc_q;
   logic                rec_q;
   logic                hw_any;
   logic [IDX_W-1:0]    hw_win;
   logic [IDX_W-1:0]    start_idx;
   logic                ack_fire;
   logic                iret_fire;
   logic                cfg_vec_ok;
   logic [ADDR_W-1:0]   soft_vec;

   function automatic logic [ADDR_W-1:0] def_vec(input int k);
      return ADDR_W'(DEF_BASE - ADDR_W'(k) * DEF_STEP);
   endfunction

   assign edge_w     = i_irq & ~irq_q;
   assign elig_w     = pend_q & mask_q;
   assign ack_fire   = (state_q == REQ) && req_q && cpu.i_ack;
   assign iret_fire  = (state_q == SERVICE) && cpu.i_iret;
   assign soft_vec   = SOFT_BASE + ADDR_W'(soft_num_q);
   assign cfg_vec_ok = {1'b0, i_cfg_idx} < (IDX_W + 1)'(NUM_IRQ);
   assign start_idx  = (mode_q && rr_q != LAST) ? rr_q + 1'b1 : '0;
   assign hw_clr     = (ack_fire && !lat_soft_q) ?
                       (NUM_IRQ'(1) << lat_id_q) : '0;

   // Pick the first eligible channel scanning upward from start_idx.
   always_comb begin
      hw_any = 1'b0;
      hw_win = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (!hw_any && elig_w[(int'(start_idx) + i) % NUM_IRQ]) begin
            hw_any = 1'b1;
            hw_win = IDX_W'((int'(start_idx) + i) % NUM_IRQ);
         end
      end
   end

   // Edge detection, pending bits and the soft request slot.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         irq_q       <= '0;
         pend_q      <= '0;
         soft_pend_q <= 1'b0;
         soft_num_q  <= '0;
      end else begin
         irq_q  <= i_irq;
         pend_q <= (pend_q & ~hw_clr) | edge_w;
         if (ack_fire && lat_soft_q) begin
            soft_pend_q <= 1'b0;
         end else if (i_soft_req && !soft_pend_q) begin
            soft_pend_q <= 1'b1;
            soft_num_q  <= i_soft_num;
         end
      end
   end

   // Configuration registers and round-robin pointer.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mask_q <= '1;
         mode_q <= 1'b0;
         rr_q   <= LAST;
         for (int k = 0; k < NUM_IRQ; k++) vec_q[k] <= def_vec(k);
      end else begin
         if (ack_fire && !lat_soft_q) rr_q <= lat_id_q;
         if (i_cfg_we) begin
            unique case (i_cfg_op)
               2'b00: mask_q <= i_data_bus[NUM_IRQ-1:0];
               2'b01: if (cfg_vec_ok) vec_q[i_cfg_idx] <= i_data_bus;
               2'b10: for (int k = 0; k < NUM_IRQ; k++) vec_q[k] <= def_vec(k);
               2'b11: if (i_data_bus[0] != mode_q) begin
                  mode_q <= i_data_bus[0];
                  rr_q   <= LAST;
               end
            endcase
         end
      end
   end

   // Service FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         lat_vec_q  <= '0;
         lat_id_q   <= '0;
         lat_soft_q <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         pc_q       <= 1'b0;
         rec_q      <= 1'b0;
      end else begin
         pc_q  <= 1'b0;
         rec_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (hw_any || soft_pend_q) begin
                  lat_vec_q  <= hw_any ? vec_q[hw_win] : soft_vec;
                  lat_id_q   <= hw_any ? hw_win : '0;
                  lat_soft_q <= !hw_any;
                  state_q    <= REQ;
               end
            end
            REQ: begin
               if (ack_fire) begin
                  req_q   <= 1'b0;
                  addr_q  <= '0;
                  pc_q    <= 1'b1;
                  state_q <= SERVICE;
               end else begin
                  req_q  <= 1'b1;
                  addr_q <= lat_vec_q;
               end
            end
            SERVICE: begin
               if (iret_fire) begin
                  rec_q   <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu.o_int_req           = req_q;
   assign cpu.o_interrupt_address = addr_q;
   assign cpu.o_int_id            = lat_id_q;
   assign cpu.o_int_soft          = lat_soft_q;
   assign cpu.o_pc_set_enable     = pc_q;
   assign cpu.o_recovery_enable   = rec_q;
   assign o_pending               = pend_q;
   assign o_busy                  = (state_q != IDLE);

endmodule

// File: doc/irq_vector_ctrl.md
IRQ_VECTOR_CTRL -- requirements
Module: irq_vector_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of external interrupt channels (2..16).
REQ-002 SHALL have parameter ADDR_W, default 16, width of vector addresses and config data.
REQ-003 SHALL have parameter DEF_BASE, default 16'hFDA9, default vector of channel 0.
REQ-004 SHALL have parameter DEF_STEP, default 16'h0256; default vector of channel k = DEF_BASE - k*DEF_STEP, mod 2^ADDR_W.
REQ-005 SHALL have parameter SOFT_BASE, default 16'd29; soft vector = SOFT_BASE + soft number, mod 2^ADDR_W.
REQ-006 SHALL use IDX_W = max(1, clog2(NUM_IRQ)) for channel indices.
REQ-007 SHALL have one clock, clk, and asynchronous active-low reset, n_rst.
REQ-008 SHALL have these ports:
- clk  in  1  clock
- n_rst  in  1  async active-low reset
- i_irq  in  NUM_IRQ  level request lines, edge-detected
- i_cfg_we  in  1  config write strobe
- i_cfg_op  in  2  00 enable mask, 01 vector[i_cfg_idx], 10 restore default vectors, 11 priority mode
- i_cfg_idx  in  IDX_W  channel for op 01
- i_data_bus  in  ADDR_W  config data
- i_soft_req  in  1  software interrupt request pulse
- i_soft_num  in  5  software interrupt number
- i_ack  in  1  CPU accepted the presented vector
- i_iret  in  1  return from interrupt
- o_int_req  out  1  vector presented
- o_interrupt_address  out  ADDR_W  presented vector
- o_int_id  out  IDX_W  serviced channel
- o_int_soft  out  1  serviced request is software
- o_pc_set_enable  out  1  one-cycle PC load pulse
- o_recovery_enable  out  1  one-cycle PC restore pulse
- o_pending  out  NUM_IRQ  pending bits
- o_busy  out  1  state != IDLE

Function
REQ-009 SHALL keep irq_q (i_irq delayed one cycle); channel k edge = i_irq[k] & ~irq_q[k].
REQ-010 SHALL set pending[k] on every edge, regardless of mask; it is visible the next cycle.
REQ-011 SHALL treat a channel as eligible when pending[k] & mask[k]; masked channels stay pending.
REQ-012 SHALL latch soft_pending and soft_num on i_soft_req when soft_pending==0; otherwise ignore the request.
REQ-013 SHALL use FSM states IDLE, REQ and SERVICE.
REQ-014 SHALL in IDLE, with any eligible channel or soft_pending: latch the winner's vector, id and soft flag, then go to REQ next cycle.
REQ-015 SHALL select the winner as follows:
- hardware channels always beat soft
- mode 0: fixed priority, lowest index wins
- mode 1: round-robin; search starts at last-serviced index + 1, mod NUM_IRQ
REQ-016 SHALL in REQ hold o_int_req=1 and stable address, id and soft flag until i_ack.
REQ-017 SHALL on i_ack in REQ: clear the winner's pending or soft bit, pulse o_pc_set_enable for one cycle, go to SERVICE, and update the round-robin pointer.
REQ-018 SHALL let a same-cycle edge on the cleared channel win: pending stays 1.
REQ-019 SHALL in SERVICE accept no new interrupts (no nesting); pending bits still accumulate.
REQ-020 SHALL on i_iret in SERVICE pulse o_recovery_enable for one cycle and go to IDLE; i_iret is ignored in IDLE and REQ.
REQ-021 SHALL ignore i_ack outside REQ.
REQ-022 SHALL apply a config write on the clock edge; writes never alter an already latched presented vector.
REQ-023 SHALL for op 11 use i_data_bus[0] as the mode; changing mode resets the round-robin pointer to NUM_IRQ-1.
REQ-024 SHALL treat an out-of-range i_cfg_idx (>= NUM_IRQ) write as a no-op.
REQ-025 SHALL drive o_interrupt_address = 0 whenever o_int_req=0.
REQ-026 SHALL give o_int_req latency of 2 cycles after the clk edge sampling the i_irq rise, when idle and enabled.

Reset
REQ-027 SHALL on n_rst low, asynchronously set:
- state IDLE; pending, soft_pending and irq_q = 0
- mask all ones; mode 0; rr pointer NUM_IRQ-1
- vectors to defaults
- all outputs 0
REQ-028 SHALL abandon any in-flight REQ or SERVICE on reset, with no o_pc_set_enable or o_recovery_enable pulse.

Verification
REQ-029 SHALL cover: i_irq[1] rise, idle -> o_int_req=1 two cycles later, address 16'hFB53, id 1; i_ack -> one o_pc_set_enable pulse, pending[1]=0.
REQ-030 SHALL cover: irq0 and irq2 rise together, mode 0 -> 16'hFDA9 serviced first; after i_iret, 16'hF8FD next.
REQ-031 SHALL cover: mode 1, all four irq pending, repeated ack/iret -> service order 0,1,2,3.
REQ-032 SHALL cover: mask=4'b1110 with irq0 edge -> no o_int_req; pending[0]=1; after mask=4'b1111 -> vector 16'hFDA9.
REQ-033 SHALL cover: i_soft_req with num 3, no hw pending -> address 16'd32, o_int_soft=1; a concurrent hw edge beats the soft request.
REQ-034 SHALL cover: n_rst low during SERVICE -> all outputs 0 immediately; vectors back to defaults; a later i_iret gives no o_recovery_enable.
